// File: rtl/service_arbiter_pkg.sv
// Shared types and sizes for the service arbiter: FSM states, service count, BCD word width.
// Pure declarations; carries no timing and no flow control.
package service_arbiter_pkg;

  localparam int NUM_SVC = 4;
  localparam int BCD_W   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } arb_state_t;

  // Fixed priority: lowest set index wins.
  function automatic logic [1:0] lowest_req(input logic [NUM_SVC-1:0] req);
    lowest_req = 2'd0;
    for (int i = NUM_SVC - 1; i >= 0; i--) begin
      if (req[i]) lowest_req = 2'(i);
    end
  endfunction

endpackage

// File: rtl/service_arbiter_if.sv
// Switch, push and display bundle between the service arbiter and its surroundings.
// Plain level signals; no handshake and no backpressure.
interface service_arbiter_if;
  import service_arbiter_pkg::*;

  logic [NUM_SVC-1:0]       spdt;
  logic                     push_m;
  logic [NUM_SVC*BCD_W-1:0] svc_data;
  logic [NUM_SVC-1:0]       svc_en;
  logic [NUM_SVC-1:0]       push_lvl;
  logic [NUM_SVC-1:0]       push_pulse;
  logic [3:0]               an;
  logic [3:0]               bcd;

  modport master (
    output spdt, push_m, svc_data,
    input  svc_en, push_lvl, push_pulse, an, bcd
  );

  modport slave (
    input  spdt, push_m, svc_data,
    output svc_en, push_lvl, push_pulse, an, bcd
  );

endinterface

// File: rtl/service_arbiter_push_conditioner.sv
// Push button conditioner: 2-flop sync, debounce, rising-edge pulse; level lags raw by 2+DEBOUNCE_CYCLES.
// Rise pulse is registered alongside the level change; no backpressure.
module push_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_raw,
  output logic lvl,
  output logic rise,
  output logic released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= push_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != lvl) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl  <= sync2;
          rise <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Low and not mid-way through accepting a press: a genuine release.
  assign released = !lvl && !sync2;

endmodule

// File: rtl/service_arbiter.sv
// Grants one of four services from SPDT requests, routes the debounced push and scans the owner's BCD word.
// spdt edge to svc_en takes 3 cycles; no backpressure, every input is sampled each cycle.
module service_arbiter
  import service_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_CYCLES     = 4
) (
  input logic              clk,
  input logic              reset,
  service_arbiter_if.slave bus
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [NUM_SVC-1:0] spdt_s1, spdt_s2;
  arb_state_t         state;
  logic [1:0]         owner;
  logic [NUM_SVC-1:0] svc_en_q;
  logic               lock;
  logic               push_lvl_int, push_rise, push_released;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit;
  logic               granted;
  logic [BCD_W-1:0]   word;
  logic [3:0]         an_d, bcd_d;

  push_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_push (
    .clk      (clk),
    .reset    (reset),
    .push_raw (bus.push_m),
    .lvl      (push_lvl_int),
    .rise     (push_rise),
    .released (push_released)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      spdt_s1  <= '0;
      spdt_s2  <= '0;
      state    <= IDLE;
      owner    <= 2'd0;
      svc_en_q <= '0;
      lock     <= 1'b0;
    end else begin
      spdt_s1 <= bus.spdt;
      spdt_s2 <= spdt_s1;
      unique case (state)
        IDLE, HANDOVER: begin
          if (|spdt_s2) begin
            state    <= GRANT;
            owner    <= lowest_req(spdt_s2);
            svc_en_q <= NUM_SVC'(1) << lowest_req(spdt_s2);
            lock     <= 1'b1;
          end else begin
            state    <= IDLE;
            svc_en_q <= '0;
          end
        end
        GRANT: begin
          // A push already held (or being accepted) at grant time must be released first.
          if (push_released) lock <= 1'b0;
          if (!spdt_s2[owner]) begin
            state    <= HANDOVER;
            svc_en_q <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          svc_en_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign granted = (state == GRANT);

  always_comb begin
    word  = bus.svc_data[{owner, 4'b0000} +: BCD_W];
    an_d  = 4'b1111;
    bcd_d = 4'd0;
    if (granted) begin
      an_d  = ~(4'b0001 << digit);
      bcd_d = word[{digit, 2'b00} +: 4];
    end
  end

  assign bus.svc_en     = svc_en_q;
  assign bus.push_lvl   = (granted && !lock && push_lvl_int) ? svc_en_q : '0;
  assign bus.push_pulse = (granted && !lock && push_rise)    ? svc_en_q : '0;
  assign bus.an         = an_d;
  assign bus.bcd        = bcd_d;

endmodule

// File: tb/tb_service_arbiter.sv
// Self-checking bench for service_arbiter: directed scenarios plus random stimulus against a behavioural model.
module tb_service_arbiter;

  localparam int DB      = 4;
  localparam int SC      = 4;
  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_GAP   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  service_arbiter_if bus ();

  service_arbiter #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_CYCLES    (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: raw inputs delayed two samples, debounce as a sample window,
  // service ownership and push release tracked as plain integers/flags.
  int         m_phase, m_owner, m_ticks;
  logic [3:0] m_sp_a, m_sp_b;
  logic       m_pm_a, m_pm_b, m_lvl, m_lvl_prev;
  bit         m_released;
  logic       m_win[$];
  logic [3:0] e_svc, e_lvl, e_pulse, e_an, e_bcd;

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic flip;
    if (reset) begin
      m_phase = P_IDLE; m_owner = 0; m_ticks = 0;
      m_sp_a = 4'h0; m_sp_b = 4'h0; m_pm_a = 1'b0; m_pm_b = 1'b0;
      m_lvl = 1'b0; m_lvl_prev = 1'b0; m_released = 1'b0;
      m_win.delete();
    end else begin
      if (m_phase == P_SERVE && !m_lvl && !m_pm_b) m_released = 1'b1;
      if (m_phase == P_SERVE) begin
        if (!m_sp_b[m_owner]) m_phase = P_GAP;
      end else if (m_sp_b != 4'h0) begin
        m_phase = P_SERVE; m_owner = lowest(m_sp_b); m_released = 1'b0;
      end else begin
        m_phase = P_IDLE;
      end
      m_win.push_back(m_pm_b);
      if (m_win.size() > DB) void'(m_win.pop_front());
      flip = (m_win.size() == DB);
      foreach (m_win[i]) if (m_win[i] == m_lvl) flip = 1'b0;
      m_lvl_prev = m_lvl;
      if (flip) m_lvl = ~m_lvl;
      m_pm_b = m_pm_a; m_pm_a = bus.push_m;
      m_sp_b = m_sp_a; m_sp_a = bus.spdt;
      m_ticks++;
    end
  endtask

  task automatic tick();
    int  digit;
    bit  serve;
    model_step();
    @(posedge clk);
    #1;
    digit   = (m_ticks / SC) % 4;
    serve   = (m_phase == P_SERVE);
    e_svc   = serve ? 4'(1 << m_owner) : 4'h0;
    e_lvl   = (serve && m_lvl && m_released) ? e_svc : 4'h0;
    e_pulse = (serve && m_lvl && !m_lvl_prev && m_released) ? e_svc : 4'h0;
    e_an    = serve ? ~4'(1 << digit) : 4'hF;
    e_bcd   = serve ? 4'(bus.svc_data >> (16 * m_owner + 4 * digit)) : 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.spdt = 4'hF; bus.push_m = 1'b1; bus.svc_data = {$urandom, $urandom};
    repeat (3) tick();
    checks++;
    if (bus.svc_en !== 4'h0) begin failures++; $display("FAIL reset_svc_en got=%b exp=0000", bus.svc_en); end
    checks++;
    if (bus.push_lvl !== 4'h0) begin failures++; $display("FAIL reset_push_lvl got=%b exp=0000", bus.push_lvl); end
    checks++;
    if (bus.push_pulse !== 4'h0) begin failures++; $display("FAIL reset_push_pulse got=%b exp=0000", bus.push_pulse); end
    checks++;
    if (bus.an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
    checks++;
    if (bus.bcd !== 4'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", bus.bcd); end
  endtask

  task automatic test_grant_push();
    logic [3:0] exp;
    int pulses = 0;
    bit lvl_seen = 0;
    bus.spdt = 4'h0; bus.push_m = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    bus.spdt = 4'b0100;
    for (int n = 1; n <= 3; n++) begin
      tick();
      exp = (n == 3) ? 4'b0100 : 4'b0000;
      checks++;
      if (bus.svc_en !== exp) begin failures++; $display("FAIL grant_latency cycle=%0d got=%b exp=%b", n, bus.svc_en, exp); end
    end
    repeat (6) tick();
    for (int n = 0; n < 32; n++) begin
      bus.push_m = (n < 20);
      tick();
      if (bus.push_pulse[2]) pulses++;
      if (bus.push_lvl == 4'b0100) lvl_seen = 1;
      checks++;
      if ({bus.svc_en, bus.push_lvl, bus.push_pulse} !== {e_svc, e_lvl, e_pulse}) begin
        failures++;
        $display("FAIL grant_push cycle=%0d got=%b/%b/%b exp=%b/%b/%b", n, bus.svc_en, bus.push_lvl, bus.push_pulse, e_svc, e_lvl, e_pulse);
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL grant_push_pulse_count got=%0d exp=1", pulses); end
    checks++;
    if (!lvl_seen) begin failures++; $display("FAIL grant_push_lvl got=never exp=push_lvl[2] high"); end
  endtask

  task automatic test_sticky();
    logic [3:0] exp;
    bus.spdt = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (bus.svc_en !== 4'b0100) begin failures++; $display("FAIL sticky_owner cycle=%0d got=%b exp=0100", n, bus.svc_en); end
    end
    bus.spdt = 4'b0001;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n < 3) ? 4'b0100 : ((n == 3) ? 4'b0000 : 4'b0001);
      checks++;
      if (bus.svc_en !== exp) begin failures++; $display("FAIL handover cycle=%0d got=%b exp=%b", n, bus.svc_en, exp); end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0, lvl_rises = 0;
    logic prev_lvl;
    bus.push_m = 1'b0;
    repeat (4) tick();
    prev_lvl = bus.push_lvl[0];
    for (int n = 0; n < 38; n++) begin
      bus.push_m = (n < 12) ? (((n / 2) % 2) == 0) : (n < 28);
      tick();
      if (bus.push_pulse[0]) pulses++;
      if (bus.push_lvl[0] && !prev_lvl) lvl_rises++;
      prev_lvl = bus.push_lvl[0];
      checks++;
      if ({bus.svc_en, bus.push_lvl, bus.push_pulse} !== {e_svc, e_lvl, e_pulse}) begin
        failures++;
        $display("FAIL bounce cycle=%0d got=%b/%b/%b exp=%b/%b/%b", n, bus.svc_en, bus.push_lvl, bus.push_pulse, e_svc, e_lvl, e_pulse);
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses); end
    checks++;
    if (lvl_rises != 1) begin failures++; $display("FAIL bounce_lvl_rises got=%0d exp=1", lvl_rises); end
  endtask

  task automatic test_handover_lockout();
    int held_pulses = 0, held_lvl = 0, later_pulses = 0;
    bus.spdt = 4'b0100; bus.push_m = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    repeat (8) tick();
    bus.push_m = 1'b1;
    repeat (10) tick();
    bus.spdt = 4'b0001;
    for (int n = 0; n < 26; n++) begin
      bus.push_m = (n < 16);
      tick();
      if (bus.push_pulse[0]) held_pulses++;
      if (bus.push_lvl[0]) held_lvl++;
      checks++;
      if ({bus.svc_en, bus.push_lvl, bus.push_pulse} !== {e_svc, e_lvl, e_pulse}) begin
        failures++;
        $display("FAIL lockout cycle=%0d got=%b/%b/%b exp=%b/%b/%b", n, bus.svc_en, bus.push_lvl, bus.push_pulse, e_svc, e_lvl, e_pulse);
      end
    end
    checks++;
    if (bus.svc_en !== 4'b0001) begin failures++; $display("FAIL lockout_owner got=%b exp=0001", bus.svc_en); end
    checks++;
    if (held_pulses != 0 || held_lvl != 0) begin
      failures++; $display("FAIL lockout_masked got pulses=%0d lvl_cycles=%0d exp=0/0", held_pulses, held_lvl);
    end
    bus.push_m = 1'b1;
    repeat (10) begin
      tick();
      if (bus.push_pulse[0]) later_pulses++;
    end
    checks++;
    if (later_pulses != 1) begin failures++; $display("FAIL lockout_repress got=%0d exp=1", later_pulses); end
  endtask

  task automatic test_scan();
    logic [63:0] d;
    logic [3:0]  exp_bcd, prev_an;
    d = {$urandom, $urandom};
    d[31:16] = 16'h5937;
    bus.svc_data = d; bus.spdt = 4'b0010; bus.push_m = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (3) tick();
    prev_an = bus.an;
    for (int n = 0; n < 40; n++) begin
      tick();
      case (bus.an)
        4'b1110: exp_bcd = 4'h7;
        4'b1101: exp_bcd = 4'h3;
        4'b1011: exp_bcd = 4'h9;
        4'b0111: exp_bcd = 4'h5;
        default: exp_bcd = 4'hX;
      endcase
      checks++;
      if (bus.bcd !== exp_bcd) begin failures++; $display("FAIL scan_digit cycle=%0d an=%b got bcd=%h exp=%h", n, bus.an, bus.bcd, exp_bcd); end
      checks++;
      if ({bus.an, bus.bcd} !== {e_an, e_bcd}) begin
        failures++; $display("FAIL scan_timing cycle=%0d got an=%b bcd=%h exp an=%b bcd=%h", n, bus.an, bus.bcd, e_an, e_bcd);
      end
      if (bus.an !== prev_an) begin
        checks++;
        if (bus.an !== {prev_an[2:0], prev_an[3]}) begin
          failures++; $display("FAIL scan_order cycle=%0d got=%b exp=%b", n, bus.an, {prev_an[2:0], prev_an[3]});
        end
      end
      prev_an = bus.an;
    end
    bus.spdt = 4'h0;
    repeat (3) tick();
    checks++;
    if ({bus.an, bus.bcd} !== {4'b1111, 4'h0}) begin
      failures++; $display("FAIL scan_blank got an=%b bcd=%h exp an=1111 bcd=0", bus.an, bus.bcd);
    end
  endtask

  task automatic test_reset_mid_grant();
    int pulses = 0, lvl_cycles = 0, later_pulses = 0;
    bus.spdt = 4'b0010; bus.push_m = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    repeat (8) tick();
    bus.push_m = 1'b1;
    repeat (8) tick();
    checks++;
    if (bus.push_lvl !== 4'b0010) begin failures++; $display("FAIL rst_mid_pre_lvl got=%b exp=0010", bus.push_lvl); end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.svc_en, bus.push_lvl, bus.push_pulse, bus.an, bus.bcd} !== {4'h0, 4'h0, 4'h0, 4'hF, 4'h0}) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b/%b/%b/%b/%h exp=0000/0000/0000/1111/0", bus.svc_en, bus.push_lvl, bus.push_pulse, bus.an, bus.bcd);
    end
    reset = 1'b0;
    repeat (15) begin
      tick();
      if (bus.push_pulse != 4'h0) pulses++;
      if (bus.push_lvl != 4'h0) lvl_cycles++;
    end
    checks++;
    if (bus.svc_en !== 4'b0010) begin failures++; $display("FAIL rst_mid_regrant got=%b exp=0010", bus.svc_en); end
    checks++;
    if (pulses != 0 || lvl_cycles != 0) begin
      failures++; $display("FAIL rst_mid_masked got pulses=%0d lvl_cycles=%0d exp=0/0", pulses, lvl_cycles);
    end
    bus.push_m = 1'b0;
    repeat (10) tick();
    bus.push_m = 1'b1;
    repeat (10) begin
      tick();
      if (bus.push_pulse[1]) later_pulses++;
    end
    checks++;
    if (later_pulses != 1) begin failures++; $display("FAIL rst_mid_repress got=%0d exp=1", later_pulses); end
  endtask

  task automatic test_random();
    int sp_hold = 0, pm_hold = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      if (sp_hold == 0) begin
        bus.spdt = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        sp_hold  = $urandom_range(1, 14);
      end else sp_hold--;
      if (pm_hold == 0) begin
        bus.push_m = 1'($urandom);
        pm_hold    = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(2, 12);
      end else pm_hold--;
      if ($urandom_range(0, 49) == 0) bus.svc_data = {$urandom, $urandom};
      reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if ({bus.svc_en, bus.push_lvl, bus.push_pulse, bus.an, bus.bcd} !== {e_svc, e_lvl, e_pulse, e_an, e_bcd}) begin
        failures++;
        $display("FAIL random t=%0d got=%b/%b/%b/%b/%h exp=%b/%b/%b/%b/%h", t,
                 bus.svc_en, bus.push_lvl, bus.push_pulse, bus.an, bus.bcd, e_svc, e_lvl, e_pulse, e_an, e_bcd);
      end
      checks++;
      if ($countones(bus.svc_en) > 1) begin failures++; $display("FAIL random_onehot t=%0d got=%b exp=at most one bit", t, bus.svc_en); end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.spdt = 4'h0; bus.push_m = 1'b0; bus.svc_data = '0;
    test_reset();
    test_grant_push();
    test_sticky();
    test_bounce();
    test_handover_lockout();
    test_scan();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/service_arbiter.md
SERVICE_ARBITER -- requirements
Module: service_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a push_m level change.
REQ-002 Parameter SCAN_CYCLES, default 4: clock cycles each display digit stays selected.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 spdt  in  4  raw service-select switches; bit n requests service n.
REQ-006 push_m  in  1  raw, asynchronous, bouncing push button.
REQ-007 svc_data  in  64  four 16-bit BCD display words; service n at bits [16n+15:16n].
REQ-008 svc_en  out  4  one-hot-or-zero enable to services; drives each service's SPDT input.
REQ-009 push_lvl  out  4  debounced push_m level, routed only to the granted service.
REQ-010 push_pulse  out  4  one-cycle rising-edge pulse of debounced push_m, routed only to the granted service.
REQ-011 an  out  4  active-low digit enables, one-hot-low or all-high.
REQ-012 bcd  out  4  BCD value of the currently scanned digit.

Function
REQ-013 Input conditioning: spdt and push_m each pass through a 2-flop synchronizer before any use.
REQ-014 Debounce: push_lvl_int changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any disagreeing sample restarts the count.
REQ-015 Arbiter FSM states IDLE, GRANT, HANDOVER; at most one svc_en bit is high in any cycle.
REQ-016 IDLE: svc_en = 0; when any synchronized spdt bit is high, go to GRANT next cycle, owner = lowest-index high bit.
REQ-017 GRANT: svc_en[owner] = 1; owner is sticky: higher-priority spdt bits rising do not preempt.
REQ-018 GRANT -> HANDOVER when synchronized spdt[owner] falls; svc_en = 0 in HANDOVER for exactly one cycle.
REQ-019 HANDOVER -> GRANT (new owner = lowest-index high bit) if any spdt high, else -> IDLE.
REQ-020 push_lvl[owner] = push_lvl_int only in GRANT; all other bits 0.
REQ-021 Push lockout: on every entry to GRANT, if push_lvl_int is high, the push is masked (push_lvl and push_pulse 0) until push_lvl_int is first seen low.
REQ-022 push_pulse[owner] asserts for exactly one cycle on each unmasked 0->1 transition of push_lvl_int in GRANT; never in IDLE or HANDOVER.
REQ-023 Display word = svc_data word of owner in GRANT; in IDLE and HANDOVER all an bits are high (blank) and bcd = 0.
REQ-024 Scan: 2-bit digit index advances every SCAN_CYCLES cycles, wrapping 3 -> 0; digit k drives an[k] = 0 and bcd = word[4k+3:4k].
REQ-025 Scan counter runs in all states; blanking only masks an and bcd.
REQ-026 Latency: raw spdt edge to svc_en change = 3 cycles (2 sync + 1 FSM); debounced push to push_pulse = same cycle as push_lvl_int rise.

Reset
REQ-027 While reset is high at a clock edge: FSM = IDLE, owner = 0, synchronizers, debounce counter, push_lvl_int, lockout, scan counter and digit index = 0.
REQ-028 Output values during/after reset: svc_en = 0, push_lvl = 0, push_pulse = 0, an = 4'b1111, bcd = 0.
REQ-029 Reset asserted mid-GRANT drops svc_en in the cycle following the edge; no HANDOVER cycle is produced.

Structure
REQ-030 Shared package holds FSM state encodings (IDLE, GRANT, HANDOVER), service count 4, and BCD word width 16.
REQ-031 One sub-module, push_conditioner (synchronizer + debounce + edge detect, DEBOUNCE_CYCLES parameter), instantiated once for push_m.

Verification
REQ-032 spdt=4'b0100 from reset, push_m pulsed clean for 20 cycles -> svc_en=4'b0100 at cycle 3, push_lvl[2] high, exactly one push_pulse[2].
REQ-033 Owner 2 granted, spdt becomes 4'b0101 -> svc_en stays 4'b0100; spdt then 4'b0001 -> one cycle svc_en=0, then 4'b0001.
REQ-034 push_m toggles every 2 cycles for 12 cycles then settles high, DEBOUNCE_CYCLES=4 -> single push_pulse, no glitch on push_lvl.
REQ-035 push_m held high across handover 2->0 -> push_pulse[0] never fires until push_m released and pressed again.
REQ-036 Owner 1, svc_data[31:16]=16'h5937, SCAN_CYCLES=4 -> an sequence 1110/1101/1011/0111, bcd 7/3/9/5, 4 cycles each; spdt=0 -> an=4'b1111.
REQ-037 Reset asserted for one cycle mid-GRANT with push_m held -> all outputs at reset values next cycle, re-grant requires push release before any pulse.
